// File: rtl/floating_point_divider.sv
// Iterative IEEE-style floating-point divider.
// Restoring division of the hidden-bit mantissas, one quotient bit per cycle,
// followed by a single rounding cycle. Subnormal operands are flushed to zero.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid / in_ready     operand handshake (ready only while idle)
//   a, b                    dividend / divisor {sign, exponent, mantissa}
//   out_valid / out_ready   result handshake; out and flags hold while stalled
//   out                     quotient a/b
//   *_flag                  exception flags, valid with out_valid
module floating_point_divider #(
  parameter int EXPONENT_WIDTH   = 8,
  parameter int MANTISSA_WIDTH   = 23,
  parameter int ROUND_TO_NEAREST = 1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] a,
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] b,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] out,
  output logic                                   underflow_flag,
  output logic                                   overflow_flag,
  output logic                                   invalid_operation_flag,
  output logic                                   divide_by_zero_flag
);
  localparam int E  = EXPONENT_WIDTH;
  localparam int M  = MANTISSA_WIDTH;
  localparam int W  = E + M + 1;
  localparam int N  = M + 3;           // integer bit + M fraction bits + guard + one extra
  localparam int CW = $clog2(N);
  localparam int EW = E + 2;           // signed headroom for ea - eb + bias
  localparam logic signed [EW-1:0] BIAS     = EW'((1 << (E - 1)) - 1);
  localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << E) - 1);
  localparam logic signed [EW-1:0] EXP_ZERO = '0;
  localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
  localparam logic [W-1:0] QNAN = {1'b1, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, DIVIDE, ROUND, DONE} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]          cnt;
  logic [M+1:0]           rem_q;
  logic [M:0]             div_q;
  logic [N-1:0]           quo_q;
  logic                   sign_q;
  logic signed [EW-1:0]   exp_q;

  // operand decode
  logic         a_sign, b_sign;
  logic [E-1:0] a_exp, b_exp;
  logic [M-1:0] a_man, b_man;
  assign {a_sign, a_exp, a_man} = a;
  assign {b_sign, b_exp, b_man} = b;

  logic a_zero, a_inf, a_nan, a_snan, b_zero, b_inf, b_nan, b_snan, res_sign;
  assign a_zero   = (a_exp == '0);
  assign b_zero   = (b_exp == '0);
  assign a_inf    = (a_exp == '1) && (a_man == '0);
  assign b_inf    = (b_exp == '1) && (b_man == '0);
  assign a_nan    = (a_exp == '1) && (a_man != '0);
  assign b_nan    = (b_exp == '1) && (b_man != '0);
  assign a_snan   = a_nan && !a_man[M-1];
  assign b_snan   = b_nan && !b_man[M-1];
  assign res_sign = a_sign ^ b_sign;

  // special-case results bypass the divider entirely
  logic         spec_hit, spec_inv, spec_dbz;
  logic [W-1:0] spec_out;
  always_comb begin
    spec_hit = 1'b1;
    spec_out = '0;
    spec_inv = 1'b0;
    spec_dbz = 1'b0;
    if (a_nan || b_nan) begin
      spec_out = QNAN;
      spec_inv = a_snan | b_snan;
    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_out = QNAN;
      spec_inv = 1'b1;
    end else if (a_inf) begin
      spec_out = {res_sign, {E{1'b1}}, {M{1'b0}}};
    end else if (b_zero) begin
      spec_out = {res_sign, {E{1'b1}}, {M{1'b0}}};
      spec_dbz = 1'b1;
    end else if (a_zero || b_inf) begin
      spec_out = {res_sign, {(W-1){1'b0}}};
    end else begin
      spec_hit = 1'b0;
    end
  end

  // one restoring step; the partial remainder stays below 2*divisor so the
  // shift never loses a set bit
  logic         rem_ge;
  logic [M+1:0] rem_diff, rem_nxt;
  assign rem_ge   = (rem_q >= {1'b0, div_q});
  assign rem_diff = rem_q - {1'b0, div_q};
  assign rem_nxt  = (rem_ge ? rem_diff : rem_q) << 1;

  // normalize, round, range-check
  logic                 g, st, rnd_up, rnd_uf, rnd_of;
  logic [M-1:0]         man;
  logic [M:0]           man_r;
  logic signed [EW-1:0] exp_n, exp_f;
  logic [W-1:0]         rnd_out;
  always_comb begin
    if (quo_q[N-1]) begin
      man   = quo_q[N-2:2];
      g     = quo_q[1];
      st    = quo_q[0] | (|rem_q);
      exp_n = exp_q;
    end else begin
      man   = quo_q[N-3:1];
      g     = quo_q[0];
      st    = |rem_q;
      exp_n = exp_q - EXP_ONE;
    end
    rnd_up  = (ROUND_TO_NEAREST != 0) && g && (st || man[0]);
    man_r   = {1'b0, man} + {{M{1'b0}}, rnd_up};
    // carry out of the mantissa leaves man_r[M-1:0] == 0, i.e. 1.0 at exp+1
    exp_f   = exp_n + $signed({{(EW-1){1'b0}}, man_r[M]});
    rnd_uf  = 1'b0;
    rnd_of  = 1'b0;
    rnd_out = {sign_q, exp_f[E-1:0], man_r[M-1:0]};
    if (exp_f <= EXP_ZERO) begin
      rnd_uf  = 1'b1;
      rnd_out = {sign_q, {(W-1){1'b0}}};
    end else if (exp_f >= EXP_MAX) begin
      rnd_of  = 1'b1;
      rnd_out = {sign_q, {E{1'b1}}, {M{1'b0}}};
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = spec_hit ? DONE : DIVIDE;
      DIVIDE:  if (cnt == CW'(N - 1)) state_nxt = ROUND;
      ROUND:   state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0; rem_q <= '0; div_q <= '0; quo_q <= '0;
      sign_q <= 1'b0; exp_q <= '0; out <= '0;
      underflow_flag <= 1'b0; overflow_flag <= 1'b0;
      invalid_operation_flag <= 1'b0; divide_by_zero_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sign_q <= res_sign;
          cnt    <= '0;
          if (spec_hit) begin
            out                    <= spec_out;
            invalid_operation_flag <= spec_inv;
            divide_by_zero_flag    <= spec_dbz;
          end else begin
            rem_q <= {1'b0, 1'b1, a_man};
            div_q <= {1'b1, b_man};
            quo_q <= '0;
            exp_q <= $signed({2'b00, a_exp}) - $signed({2'b00, b_exp}) + BIAS;
          end
        end
        DIVIDE: begin
          quo_q <= {quo_q[N-2:0], rem_ge};
          rem_q <= rem_nxt;
          cnt   <= (cnt == CW'(N - 1)) ? '0 : cnt + CW'(1);
        end
        ROUND: begin
          out            <= rnd_out;
          underflow_flag <= rnd_uf;
          overflow_flag  <= rnd_of;
        end
        DONE: if (out_ready) begin
          out <= '0;
          underflow_flag <= 1'b0; overflow_flag <= 1'b0;
          invalid_operation_flag <= 1'b0; divide_by_zero_flag <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_floating_point_divider.sv
// Bench for floating_point_divider: two FP32 instances (round-to-nearest and
// truncate) driven in lockstep, fixed vectors, a reference model, and
// back-pressure / mid-division reset sequences.
module tb_floating_point_divider;
  localparam int LAT_NORM = 23 + 3 + 2;

  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] a = '0, b = '0;
  logic        r0, r1, v0, v1, uf0, of0, inv0, dbz0, uf1, of1, inv1, dbz1;
  logic [31:0] o0, o1;
  logic [3:0]  f0, f1;
  assign f0 = {uf0, of0, inv0, dbz0};
  assign f1 = {uf1, of1, inv1, dbz1};

  always #5 clk = ~clk;

  floating_point_divider #(.ROUND_TO_NEAREST(1)) dut_rne (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r0), .a(a), .b(b),
    .out_valid(v0), .out_ready(out_ready), .out(o0), .underflow_flag(uf0),
    .overflow_flag(of0), .invalid_operation_flag(inv0), .divide_by_zero_flag(dbz0));
  floating_point_divider #(.ROUND_TO_NEAREST(0)) dut_rtz (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r1), .a(a), .b(b),
    .out_valid(v1), .out_ready(out_ready), .out(o1), .underflow_flag(uf1),
    .overflow_flag(of1), .invalid_operation_flag(inv1), .divide_by_zero_flag(dbz1));

  int n_vec = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: exact integer quotient of the scaled significands, then
  // IEEE-style rounding and range clamping. Flags = {uf, of, inv, dbz}.
  function automatic void model(input logic [31:0] x, input logic [31:0] y, input bit rtn,
                                output logic [31:0] r, output logic [3:0] fl, output bit spec);
    int ex = int'(x[30:23]), ey = int'(y[30:23]), e;
    bit s = x[31] ^ y[31];
    bit xz = (ex == 0), yz = (ey == 0);
    bit xi = (ex == 255) && (x[22:0] == 0), yi = (ey == 255) && (y[22:0] == 0);
    bit xn = (ex == 255) && (x[22:0] != 0), yn = (ey == 255) && (y[22:0] != 0);
    logic [63:0] num, den, qq, rr;
    logic [23:0] m;
    bit g, st;
    fl = 4'b0000; spec = 1'b1; r = 32'h0;
    if (xn || yn) begin
      r = 32'hFFC00000; fl[1] = (xn && !x[22]) || (yn && !y[22]);
    end else if ((xz && yz) || (xi && yi)) begin
      r = 32'hFFC00000; fl[1] = 1'b1;
    end else if (xi) r = {s, 8'hFF, 23'h0};
    else if (yz) begin r = {s, 8'hFF, 23'h0}; fl[0] = 1'b1; end
    else if (xz || yi) r = {s, 31'h0};
    else begin
      spec = 1'b0;
      num = 64'({1'b1, x[22:0]}) << 40;
      den = 64'({1'b1, y[22:0]});
      qq = num / den; rr = num % den;
      e = ex - ey + 127;
      if (qq[40]) begin
        m = {1'b0, qq[39:17]}; g = qq[16]; st = (qq[15:0] != 0) || (rr != 0);
      end else begin
        m = {1'b0, qq[38:16]}; g = qq[15]; st = (qq[14:0] != 0) || (rr != 0); e = e - 1;
      end
      if (rtn && g && (st || m[0])) m = m + 24'd1;
      if (m[23]) begin e = e + 1; m = 24'd0; end
      if (e <= 0) begin r = {s, 31'h0}; fl[3] = 1'b1; end
      else if (e >= 255) begin r = {s, 8'hFF, 23'h0}; fl[2] = 1'b1; end
      else r = {s, e[7:0], m[22:0]};
    end
  endfunction

  // Issue one operation (called at a falling edge while idle), wait for the
  // result, check both instances, let it drain with out_ready high.
  task automatic run_op(input string nm, input logic [31:0] xa, input logic [31:0] xb,
                        input logic [31:0] e1, input logic [31:0] e0,
                        input logic [3:0] fe1, input logic [3:0] fe0, input int lat);
    int e;
    a = xa; b = xb; in_valid = 1'b1;
    for (e = 1; e <= 60; e++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (v0) break;
    end
    chk({nm, " latency"}, e, lat);
    chk({nm, " out rne"}, o0, e1);
    chk({nm, " flags rne"}, {28'h0, f0}, {28'h0, fe1});
    chk({nm, " valid rtz"}, {31'h0, v1}, 32'h1);
    chk({nm, " out rtz"}, o1, e0);
    chk({nm, " flags rtz"}, {28'h0, f1}, {28'h0, fe0});
    @(posedge clk); #1;
    chk({nm, " drained"}, {30'h0, v0, r0}, 32'h1);
    @(negedge clk);
  endtask

  task automatic run_model(input string nm, input logic [31:0] xa, input logic [31:0] xb);
    logic [31:0] e1, e0;
    logic [3:0]  fe1, fe0;
    bit sp;
    model(xa, xb, 1'b1, e1, fe1, sp);
    model(xa, xb, 1'b0, e0, fe0, sp);
    run_op(nm, xa, xb, e1, e0, fe1, fe0, sp ? 1 : LAT_NORM);
  endtask

  function automatic logic [31:0] rnd_op();
    logic sg = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 15))
      0:       return {sg, 31'h0};
      1:       return {sg, 8'hFF, 23'h0};
      2:       return {sg, 8'hFF, 1'b1, 22'($urandom)};
      3:       return {sg, 8'hFF, 1'b0, 22'($urandom) | 22'd1};
      4:       return {sg, 8'h00, 23'($urandom)};
      5:       return $urandom;
      default: return {sg, 8'($urandom_range(60, 195)), 23'($urandom)};
    endcase
  endfunction

  typedef struct {
    logic [31:0] a, b, e1, e0;
    logic [3:0]  fl;
    int          lat;
  } vec_t;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[13];
    int   nv;
    logic [31:0] held;
    tbl[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 32'h40400000, 4'b0000, LAT_NORM};
    tbl[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 32'h3EAAAAAA, 4'b0000, LAT_NORM};
    tbl[2]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 32'h7F800000, 4'b0001, 1};
    tbl[3]  = '{32'h00000000, 32'h00000000, 32'hFFC00000, 32'hFFC00000, 4'b0010, 1};
    tbl[4]  = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 32'h7F800000, 4'b0100, LAT_NORM};
    tbl[5]  = '{32'h00800000, 32'h40000000, 32'h00000000, 32'h00000000, 4'b1000, LAT_NORM};
    tbl[6]  = '{32'h7F800000, 32'h7F800000, 32'hFFC00000, 32'hFFC00000, 4'b0010, 1};
    tbl[7]  = '{32'h7F800001, 32'h3F800000, 32'hFFC00000, 32'hFFC00000, 4'b0010, 1};
    tbl[8]  = '{32'h7FC00000, 32'h3F800000, 32'hFFC00000, 32'hFFC00000, 4'b0000, 1};
    tbl[9]  = '{32'h00000000, 32'h40A00000, 32'h00000000, 32'h00000000, 4'b0000, 1};
    tbl[10] = '{32'h40A00000, 32'hFF800000, 32'h80000000, 32'h80000000, 4'b0000, 1};
    tbl[11] = '{32'hFF800000, 32'h40000000, 32'hFF800000, 32'hFF800000, 4'b0000, 1};
    tbl[12] = '{32'hC0C00000, 32'h40000000, 32'hC0400000, 32'hC0400000, 4'b0000, LAT_NORM};

    // reset state
    repeat (2) @(negedge clk);
    chk("reset valid/ready", {30'h0, v0, r0}, 32'h1);
    chk("reset out", o0, 32'h0);
    chk("reset flags", {28'h0, f0}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++)
      run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].e1, tbl[i].e0,
             tbl[i].fl, tbl[i].fl, tbl[i].lat);

    // back-pressure: result held, new request ignored while stalled
    out_ready = 1'b0;
    a = 32'h40C00000; b = 32'h40000000; in_valid = 1'b1;
    nv = 0;
    for (int e = 1; e <= 60 && !v0; e++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      nv = e;
    end
    chk("stall latency", nv, LAT_NORM);
    held = o0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = 32'h3F800000; b = 32'h00000000; in_valid = 1'b1;
      @(posedge clk); #1;
      chk("stall out", o0, 32'h40400000);
      chk("stall hold", o0, held);
      chk("stall valid/ready/flags", {26'h0, v0, r0, f0}, {26'h0, 1'b1, 1'b0, 4'h0});
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release idle", {30'h0, v0, r0}, 32'h1);
    @(posedge clk); #1;
    chk("ignored request", {31'h0, v0}, 32'h0);
    @(negedge clk);

    // reset during division aborts it
    a = 32'h40C00000; b = 32'h40000000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort valid/ready", {30'h0, v0, r0}, 32'h1);
    chk("abort out", o0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    nv = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (v0 || v1) nv++;
    end
    chk("abort no result", nv, 0);
    @(negedge clk);
    run_op("after abort", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 32'h3EAAAAAA,
           4'b0000, 4'b0000, LAT_NORM);

    // randomized against the model
    for (int i = 0; i < 250; i++)
      run_model($sformatf("rand%0d", i), rnd_op(), rnd_op());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
